ahb_gpio_port: RTL and testbench

AHB-Lite slave providing a parametrised general-purpose I/O port for the M0 AHB-Lite system. It is the successor to the single-register output port. It adds:
- byte-lane writes
- atomic set/clear/toggle of output bits
- a synchronised input port
- rising-edge interrupt capture with enable and write-1-to-clear status

All accesses are zero-wait-state. The block sits on the AHB-Lite decoder like any other slave.

---
 rtl/ahb_gpio_port.sv | 87 ++++++++
 tb/tb_ahb_gpio_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_gpio_port.sv
// ahb_gpio_port: zero-wait AHB-Lite GPIO slave with byte-lane writes, atomic set/clear/toggle,
// a synchronised input port and rising-edge interrupt capture (enable + write-1-to-clear status).
module ahb_gpio_port #(
    parameter int WIDTH = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [31:0]      HADDR,
    input  logic [31:0]      HWDATA,
    input  logic [2:0]       HSIZE,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic             HREADY,
    input  logic             HSEL,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    output logic [WIDTH-1:0] oPort,
    input  logic [WIDTH-1:0] iPort,
    output logic             IRQ
);
    logic             cap, dp_wr, dp_rd, unused;
    logic [2:0]       dp_off;
    logic [3:0]       lanes, dp_lanes;
    logic [31:0]      bmask;
    logic [WIDTH-1:0] wd, keep, rise, rd_sel;
    logic [WIDTH-1:0] ien, istat, sync1, sync2, prev;
    logic [WIDTH-1:0] port_nxt, ien_nxt, istat_nxt;

    assign unused    = ^HADDR[31:5];
    assign HREADYOUT = 1'b1;
    assign cap       = HSEL && HREADY && HTRANS != 2'b00;
    assign lanes     = HSIZE == 3'b010 ? 4'b1111 :
                       HSIZE == 3'b001 ? (HADDR[1] ? 4'b1100 : 4'b0011) :
                       HSIZE == 3'b000 ? 4'b0001 << HADDR[1:0] : 4'b0000;
    assign bmask     = {{8{dp_lanes[3]}}, {8{dp_lanes[2]}}, {8{dp_lanes[1]}}, {8{dp_lanes[0]}}};
    assign wd        = WIDTH'(HWDATA & bmask);
    assign keep      = ~WIDTH'(bmask);
    assign rise      = sync2 & ~prev;

    // set/clear/toggle/W1C treat disabled lanes as 0; DOUT/IEN keep old bits in disabled lanes
    always_comb begin
        port_nxt  = !dp_wr        ? oPort :
                    dp_off == 3'd0 ? (oPort & keep) | wd :
                    dp_off == 3'd1 ? oPort | wd :
                    dp_off == 3'd2 ? oPort & ~wd :
                    dp_off == 3'd3 ? oPort ^ wd : oPort;
        ien_nxt   = dp_wr && dp_off == 3'd5 ? (ien & keep) | wd : ien;
        istat_nxt = (istat & ~(dp_wr && dp_off == 3'd6 ? wd : '0)) | rise;
        rd_sel    = dp_off == 3'd4 ? sync2 :
                    dp_off == 3'd5 ? ien :
                    dp_off == 3'd6 ? istat :
                    dp_off == 3'd7 ? '0 : oPort;
        HRDATA            = '0;
        HRDATA[WIDTH-1:0] = dp_rd ? rd_sel : '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_wr    <= 1'b0;
            dp_rd    <= 1'b0;
            dp_off   <= '0;
            dp_lanes <= '0;
            oPort    <= RESET_VALUE;
            ien      <= '0;
            istat    <= '0;
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            IRQ      <= 1'b0;
        end else begin
            dp_wr    <= cap && HWRITE;
            dp_rd    <= cap && !HWRITE;
            if (cap) begin
                dp_off   <= HADDR[4:2];
                dp_lanes <= lanes;
            end
            oPort    <= port_nxt;
            ien      <= ien_nxt;
            istat    <= istat_nxt;
            sync1    <= iPort;
            sync2    <= sync1;
            prev     <= sync2;
            IRQ      <= |(istat_nxt & ien_nxt);
        end
    end
endmodule

// File: tb/tb_ahb_gpio_port.sv
// tb_ahb_gpio_port: directed test-plan checks plus randomized AHB traffic against a transaction-level model.
module tb_ahb_gpio_port;
    localparam int W = 16;
    localparam logic [W-1:0] RV = 16'hA5A5;
    localparam logic [31:0] WM = 32'h0000FFFF;

    logic HCLK = 0, HRESETn = 0, HWRITE = 0, HREADY = 1, HSEL = 0;
    logic [31:0] HADDR = 0, HWDATA = 0;
    logic [2:0] HSIZE = 0;
    logic [1:0] HTRANS = 0;
    logic [31:0] HRDATA;
    logic HREADYOUT, IRQ;
    logic [W-1:0] oPort, iPort = 0;
    int passed = 0, total = 0;

    ahb_gpio_port #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .oPort(oPort), .iPort(iPort), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // model state: registers, iPort samples from the last three edges, pending data phase
    logic [31:0] m_port = 32'(RV), m_ien = 0, m_istat = 0;
    logic [31:0] h0 = 0, h1 = 0, h2 = 0;
    logic p_wr = 0, p_rd = 0;
    logic [2:0] p_off = 0;
    logic [31:0] p_bm = 0;

    function automatic logic [31:0] lane_mask(input logic [2:0] sz, input logic [1:0] a);
        int n, st;
        logic [31:0] m;
        m = 0;
        if (sz > 3'd2) return 0;
        n = 1 << sz;
        st = int'(a) & ~(n - 1);
        for (int i = 0; i < 4; i++) if (i >= st && i < st + n) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [31:0] wdat();
        return HWDATA & p_bm & WM;
    endfunction

    function automatic logic [31:0] nxt_port();
        if (!p_wr) return m_port;
        case (p_off)
            3'd0: return (m_port & ~p_bm) | wdat();
            3'd1: return m_port | wdat();
            3'd2: return m_port & ~wdat();
            3'd3: return m_port ^ wdat();
            default: return m_port;
        endcase
    endfunction

    function automatic logic [31:0] nxt_ien();
        return (p_wr && p_off == 3'd5) ? ((m_ien & ~p_bm) | wdat()) : m_ien;
    endfunction

    function automatic logic [31:0] nxt_istat();
        logic [31:0] clr;
        clr = (p_wr && p_off == 3'd6) ? wdat() : 0;
        return (m_istat & ~clr) | (h1 & ~h2);
    endfunction

    function automatic logic [31:0] exp_rd();
        if (!p_rd) return 0;
        case (p_off)
            3'd4: return h1;
            3'd5: return m_ien;
            3'd6: return m_istat;
            3'd7: return 0;
            default: return m_port;
        endcase
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_port <= 32'(RV); m_ien <= 0; m_istat <= 0;
            h0 <= 0; h1 <= 0; h2 <= 0;
            p_wr <= 0; p_rd <= 0;
        end else begin
            m_port  <= nxt_port();
            m_ien   <= nxt_ien();
            m_istat <= nxt_istat();
            h0 <= 32'(iPort); h1 <= h0; h2 <= h1;
            p_wr  <= HSEL && HREADY && HTRANS != 2'b00 && HWRITE;
            p_rd  <= HSEL && HREADY && HTRANS != 2'b00 && !HWRITE;
            p_off <= HADDR[4:2];
            p_bm  <= lane_mask(HSIZE, HADDR[1:0]);
        end
    end

    always @(negedge HCLK) begin
        check("hrdata", HRDATA, exp_rd());
        check("oport", 32'(oPort), m_port);
        check("irq", 32'(IRQ), {31'b0, |(m_istat & m_ien)});
        check("hreadyout", 32'(HREADYOUT), 32'd1);
    end

    task automatic xfer(input logic w, input logic [4:0] a, input logic [2:0] sz,
                        input logic [31:0] d, output logic [31:0] r);
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = w; HADDR = {27'b0, a}; HSIZE = sz;
        @(negedge HCLK);
        HSEL = 0; HTRANS = 2'b00; HWDATA = d;
        r = HRDATA;
    endtask

    task automatic wr(input logic [4:0] a, input logic [2:0] sz, input logic [31:0] d);
        logic [31:0] r;
        xfer(1'b1, a, sz, d, r);
        @(negedge HCLK);
    endtask

    task automatic rd(input logic [4:0] a, input string nm, input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, a, 3'd2, 32'h0, r);
        check(nm, r, exp);
    endtask

    initial begin
        repeat (3) @(negedge HCLK);
        #2 HRESETn = 1;
        #1 check("rst_oport", 32'(oPort), 32'h0000A5A5);
        check("rst_irq", 32'(IRQ), 0);
        check("rst_hrdata", HRDATA, 0);
        rd(5'd0, "rst_dout", 32'h0000A5A5);
        rd(5'd20, "rst_ien", 0);
        rd(5'd24, "rst_istat", 0);
        rd(5'd16, "rst_din", 0);
        @(negedge HCLK);
        check("idle_hrdata", HRDATA, 0);

        wr(5'd0, 3'd2, 32'h1234FFFF);
        check("word_dout", 32'(oPort), 32'h0000FFFF);
        wr(5'd1, 3'd0, 32'h00007700);
        check("byte_dout", 32'(oPort), 32'h000077FF);
        rd(5'd0, "byte_dout_rd", 32'h000077FF);

        wr(5'd0, 3'd2, 32'h000000F0);
        wr(5'd4, 3'd2, 32'h00000003);
        check("dset", 32'(oPort), 32'h000000F3);
        wr(5'd8, 3'd2, 32'h000000F0);
        check("dclr", 32'(oPort), 32'h00000003);
        wr(5'd12, 3'd2, 32'h0000FFFF);
        check("dtgl", 32'(oPort), 32'h0000FFFC);
        wr(5'd6, 3'd1, 32'h0000FFFF);
        check("dset_hi_half", 32'(oPort), 32'h0000FFFC);

        wr(5'd20, 3'd2, 32'h00000001);
        iPort = 16'h0001;
        @(negedge HCLK);
        check("irq_k", 32'(IRQ), 0);
        @(negedge HCLK);
        check("irq_k1", 32'(IRQ), 0);
        @(negedge HCLK);
        check("irq_k2", 32'(IRQ), 1);
        iPort = 16'h0009;
        repeat (4) @(negedge HCLK);
        rd(5'd24, "istat_9", 32'h9);
        check("irq_bit3_masked", 32'(IRQ), 1);
        wr(5'd24, 3'd2, 32'h1);
        rd(5'd24, "istat_w1c", 32'h8);
        check("irq_cleared", 32'(IRQ), 0);

        iPort = 16'h0008;
        repeat (3) @(negedge HCLK);
        wr(5'd24, 3'd2, 32'h1);
        iPort = 16'h0009;
        wr(5'd24, 3'd2, 32'h1);
        check("set_wins_irq", 32'(IRQ), 1);
        rd(5'd24, "set_wins_istat", 32'h9);

        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'd4; HSIZE = 3'd2;
        @(negedge HCLK);
        HSEL = 0; HTRANS = 2'b00; HWDATA = 32'h00000F00;
        #2 HRESETn = 0;
        #1 check("arst_oport", 32'(oPort), 32'h0000A5A5);
        check("arst_irq", 32'(IRQ), 0);
        check("arst_hrdata", HRDATA, 0);
        @(negedge HCLK);
        #2 HRESETn = 1;
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b00; HWRITE = 1; HADDR = 32'd0; HSIZE = 3'd2;
        @(negedge HCLK);
        HSEL = 0; HTRANS = 2'b10; HWDATA = 32'h0;
        @(negedge HCLK);
        HTRANS = 2'b00; HWDATA = 32'h0;
        @(negedge HCLK);
        check("idle_nochange", 32'(oPort), 32'h0000A5A5);
        rd(5'd0, "post_rst_dout", 32'h0000A5A5);

        for (int i = 0; i < 4000; i++) begin
            @(negedge HCLK);
            HSEL   = $urandom_range(0, 3) != 0;
            HTRANS = 2'($urandom);
            HREADY = (p_wr || p_rd) ? 1'b1 : ($urandom_range(0, 7) != 0);
            HWRITE = 1'($urandom);
            HADDR  = 32'($urandom_range(0, 31));
            HSIZE  = $urandom_range(0, 7) < 6 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            HWDATA = $urandom;
            if ($urandom_range(0, 3) == 0) iPort = W'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 HRESETn = 0;
                @(negedge HCLK);
                #2 HRESETn = 1;
            end
        end
        @(negedge HCLK);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
